// File: rtl/shift_add_mul_pkg.sv
// rtl/shift_add_mul_pkg.sv - shared state encoding for the shift-add multiplier
// One-hot FSM states and the iteration counter width helper.
package shift_add_mul_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_LOAD  = 5'b00010,
    ST_ADD   = 5'b00100,
    ST_SHIFT = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  // Enough bits to hold the value WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// rtl/shift_add_mul_if.sv - request/result bundle for the shift-add multiplier
// master drives the request side, slave is the multiplier.
interface shift_add_mul_if
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = 6
);

  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 load_w_out;
  logic                 cnt_out;
  logic [STATE_W-1:0]   ps_out;
  logic [STATE_W-1:0]   ns_out;

  modport master (
    output start, a_in, b_in,
    input  ready, done, product, load_w_out, cnt_out, ps_out, ns_out
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, done, product, load_w_out, cnt_out, ps_out, ns_out
  );

endinterface

// File: rtl/shift_add_mul_dp.sv
// rtl/shift_add_mul_dp.sv - w/b/s registers, adder, shifter and product register
// Optional zero-operand early exit under SHIFT_ADD_MUL_EARLY_EXIT_EN.
module shift_add_mul_dp #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic                 shift_en,
  input  logic                 prod_load,
  input  logic                 prod_zero,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 early_exit,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   w_q, w_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     s_q, s_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  always_comb begin
    w_d       = w_q;
    b_d       = b_q;
    s_d       = s_q;
    product_d = product_q;
    if (capture) begin
      w_d = a_in;
      b_d = b_in;
    end
    if (clear) begin
      s_d = '0;
    end
    if (add_en && b_q[0]) begin
      s_d = s_q + {1'b0, w_q};
    end
    if (shift_en) begin
      s_d = {1'b0, s_q[WIDTH:1]};
      b_d = {s_q[0], b_q[WIDTH-1:1]};
    end
    // Loaded alongside the final shift, so take the post-shift low 2*WIDTH bits.
    if (prod_load) begin
      product_d = prod_zero ? '0 : {s_q, b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      product_q <= '0;
    end else begin
      w_q       <= w_d;
      b_q       <= b_d;
      s_q       <= s_d;
      product_q <= product_d;
    end
  end

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  assign early_exit = (w_q == '0) || (b_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign product = product_q;

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - one-hot FSM top for the shift-add multiplier
// Early exit on zero operands is enabled by SHIFT_ADD_MUL_EARLY_EXIT_EN.
module shift_add_mul_ctrl
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           reset,
  shift_add_mul_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             load_w_q, load_w_d;
  logic             cnt_out_q, cnt_out_d;

  logic capture, clear, add_en, shift_en, prod_load, prod_zero;
  logic early_exit;

  always_comb begin
    ps_d      = ps_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    clear     = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    prod_load = 1'b0;
    prod_zero = 1'b0;
    case (ps_q)
      ST_IDLE: begin
        if (bus.start) begin
          ps_d    = ST_LOAD;
          capture = 1'b1;
        end
      end
      ST_LOAD: begin
        clear = 1'b1;
        cnt_d = '0;
        if (early_exit) begin
          ps_d      = ST_DONE;
          prod_load = 1'b1;
          prod_zero = 1'b1;
        end else begin
          ps_d = ST_ADD;
        end
      end
      ST_ADD: begin
        add_en = 1'b1;
        ps_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          ps_d      = ST_DONE;
          prod_load = 1'b1;
        end else begin
          ps_d = ST_ADD;
        end
      end
      ST_DONE: ps_d = ST_IDLE;
      default: ps_d = ST_IDLE;
    endcase
    // Outputs are registered as decodes of the next state so they track ps_q exactly.
    ready_d   = (ps_d == ST_IDLE);
    done_d    = (ps_d == ST_DONE);
    load_w_d  = (ps_d == ST_LOAD);
    cnt_out_d = (ps_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q      <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      load_w_q  <= 1'b0;
      cnt_out_q <= 1'b0;
    end else begin
      ps_q      <= ps_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      load_w_q  <= load_w_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  shift_add_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture),
    .clear      (clear),
    .add_en     (add_en),
    .shift_en   (shift_en),
    .prod_load  (prod_load),
    .prod_zero  (prod_zero),
    .a_in       (bus.a_in),
    .b_in       (bus.b_in),
    .early_exit (early_exit),
    .product    (bus.product)
  );

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.load_w_out = load_w_q;
  assign bus.cnt_out    = cnt_out_q;
  assign bus.ps_out     = ps_q;
  assign bus.ns_out     = ps_d;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - directed self-checking bench for shift_add_mul_ctrl
// Expected latencies depend on SHIFT_ADD_MUL_EARLY_EXIT_EN.
module tb_shift_add_mul_ctrl;

  localparam int WIDTH = 6;
  localparam int LAT_FULL = 2 * WIDTH + 1;
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  localparam int LAT_ZERO = 1;
  localparam int CNT_ZERO = 0;
`else
  localparam int LAT_ZERO = LAT_FULL;
  localparam int CNT_ZERO = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   cnts;
  int   pulses;

  shift_add_mul_if #(.WIDTH(WIDTH)) bus ();

  shift_add_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges from the LOAD cycle until done is seen, bounded.
  task automatic wait_done(output int n, output int c);
    n = 0;
    c = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.cnt_out === 1'b1) c++;
      step();
      n++;
    end
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_load_w", 32'(bus.load_w_out), 32'd0);
    chk("rst_cnt_out", 32'(bus.cnt_out), 32'd0);
    chk("rst_ps", 32'(bus.ps_out), 32'b00001);

    // 6 x 7
    launch(6'd6, 6'd7);
    chk("t1_ps_load", 32'(bus.ps_out), 32'b00010);
    chk("t1_load_w", 32'(bus.load_w_out), 32'd1);
    chk("t1_ns_add", 32'(bus.ns_out), 32'b00100);
    wait_done(lat, cnts);
    chk("t1_latency", 32'(lat), 32'(LAT_FULL));
    chk("t1_shifts", 32'(cnts), 32'(WIDTH));
    chk("t1_ps_done", 32'(bus.ps_out), 32'b10000);
    chk("t1_product", 32'(bus.product), 32'd42);
    step();
    chk("t1_done_1cyc", 32'(bus.done), 32'd0);
    chk("t1_ready_after", 32'(bus.ready), 32'd1);
    chk("t1_product_hold", 32'(bus.product), 32'd42);

    // 63 x 63 drives a carry into the top bit of s
    launch(6'd63, 6'd63);
    wait_done(lat, cnts);
    chk("t2_latency", 32'(lat), 32'(LAT_FULL));
    chk("t2_product", 32'(bus.product), 32'd3969);
    step();

    // Zero multiplicand
    launch(6'd0, 6'd45);
    wait_done(lat, cnts);
    chk("t3_latency", 32'(lat), 32'(LAT_ZERO));
    chk("t3_shifts", 32'(cnts), 32'(CNT_ZERO));
    chk("t3_product", 32'(bus.product), 32'd0);
    step();

    // Start re-asserted mid-operation must be ignored
    launch(6'd9, 6'd10);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        bus.start = 1'b1;
        bus.a_in  = 6'd63;
        bus.b_in  = 6'd63;
      end
      if (lat == 5) bus.start = 1'b0;
      step();
      lat++;
    end
    bus.start = 1'b0;
    chk("t4_latency", 32'(lat), 32'(LAT_FULL));
    chk("t4_product", 32'(bus.product), 32'd90);
    step();
    chk("t4_idle", 32'(bus.ps_out), 32'b00001);

    // Reset during SHIFT of iteration 3, with start also high
    launch(6'd5, 6'd9);
    for (int i = 0; i < 6; i++) step();
    chk("t5_ps_shift", 32'(bus.ps_out), 32'b01000);
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("t5_ps_idle", 32'(bus.ps_out), 32'b00001);
    chk("t5_product", 32'(bus.product), 32'd0);
    chk("t5_ready", 32'(bus.ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) pulses++;
      step();
    end
    chk("t5_no_done", 32'(pulses), 32'd0);

    // Start held high: 5 x 9 then 12 x 12
    bus.start = 1'b1;
    bus.a_in  = 6'd5;
    bus.b_in  = 6'd9;
    step();
    wait_done(lat, cnts);
    chk("t6a_latency", 32'(lat), 32'(LAT_FULL));
    chk("t6a_product", 32'(bus.product), 32'd45);
    chk("t6a_ns_idle", 32'(bus.ns_out), 32'b00001);
    bus.a_in = 6'd12;
    bus.b_in = 6'd12;
    step();
    chk("t6_gap_idle", 32'(bus.ps_out), 32'b00001);
    chk("t6_gap_product", 32'(bus.product), 32'd45);
    step();
    chk("t6b_ps_load", 32'(bus.ps_out), 32'b00010);
    wait_done(lat, cnts);
    bus.start = 1'b0;
    chk("t6b_latency", 32'(lat), 32'(LAT_FULL));
    chk("t6b_product", 32'(bus.product), 32'd144);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
